// File: rtl/icache.sv
// icache: direct-mapped instruction cache, 2**IDX_W lines of 64 bits, one outstanding miss.
// Define ICACHE_PERF_EN to add saturating hit_count/miss_count outputs.
module icache #(
   parameter int unsigned IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   input  logic        req,
   output logic [31:0] instr,
   output logic        stall,
   output logic        imiss,
   output logic [31:0] iaddr,
   input  logic [63:0] fill_data,
   input  logic        ifill
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned LINES = 2**IDX_W;
   localparam int unsigned TAG_W = 29 - IDX_W;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state_q, state_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [28:0]      laddr_q, laddr_d;
   logic             imiss_q, imiss_d;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [63:0]      data_q [LINES];

   logic [IDX_W-1:0] idx, fill_idx;
   logic [TAG_W-1:0] pc_tag, fill_tag;
   logic [63:0]      line;
   logic             hit, miss_start, fill_en;
   logic             unused_pc;

   assign idx       = pc[3+IDX_W-1:3];
   assign pc_tag    = pc[31:3+IDX_W];
   assign fill_idx  = laddr_q[IDX_W-1:0];
   assign fill_tag  = laddr_q[28:IDX_W];
   assign unused_pc = ^pc[1:0];

   // Lookups only hit in IDLE, so a line refilled this cycle is seen one cycle later.
   assign line  = data_q[idx];
   assign hit   = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == pc_tag);
   assign stall = req & ~hit;
   assign instr = pc[2] ? line[63:32] : line[31:0];
   assign imiss = imiss_q;
   assign iaddr = {laddr_q, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= '0;
         laddr_q <= '0;
         imiss_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         laddr_q <= laddr_d;
         imiss_q <= imiss_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req && !hit) state_d = WAIT;
         WAIT:    if (ifill) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      miss_start = 1'b0;
      fill_en    = 1'b0;
      imiss_d    = imiss_q;
      laddr_d    = laddr_q;
      valid_d    = valid_q;
      unique case (state_q)
         IDLE: begin
            if (req && !hit) begin
               miss_start = 1'b1;
               imiss_d    = 1'b1;
               laddr_d    = pc[31:3];
            end
         end
         WAIT: begin
            if (ifill) begin
               fill_en           = 1'b1;
               imiss_d           = 1'b0;
               valid_d[fill_idx] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Refill targets the latched miss address; pc may have moved on.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= fill_data;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (req && hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss_start && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: table-driven fetches plus hand-written miss/fill/reset sequences,
// with a 3-cycle-latency memory model and instruction/request scoreboards.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = '0;
   logic        req = 1'b0;
   logic [63:0] fill_data = '0;
   logic        ifill = 1'b0;
   logic [31:0] instr, iaddr;
   logic        stall, imiss;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   icache #(.IDX_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc        (pc),
      .req       (req),
      .instr     (instr),
      .stall     (stall),
      .imiss     (imiss),
      .iaddr     (iaddr),
      .fill_data (fill_data),
      .ifill     (ifill)
`ifdef ICACHE_PERF_EN
      ,
      .hit_count (hit_count),
      .miss_count(miss_count)
`endif
   );

   int checks = 0;
   int failures = 0;
   int mem_reqs = 0;
   int exp_misses = 0;
   int exp_hits = 0;
   logic [31:0] exp_line_q[$];
   logic [31:0] exp_instr_q[$];

   typedef struct {
      logic [31:0] pc;
      logic        miss;
      logic [31:0] instr;
   } vec_t;

   function automatic logic [63:0] line_for(input logic [31:0] a);
      if (a == 32'h40) return 64'h11112222_33334444;
      return {a ^ 32'hA5A5_0000, ~a};
   endfunction

   function automatic logic [31:0] instr_for(input logic [31:0] a);
      logic [63:0] l;
      l = line_for({a[31:3], 3'b000});
      return a[2] ? l[63:32] : l[31:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Memory: ifill three cycles after a request is seen; re-samples imiss right after ifill.
   logic        mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   always @(posedge clk) begin
      #1;
      ifill = 1'b0;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            ifill     = 1'b1;
            fill_data = line_for(mem_addr);
            mem_busy  = 1'b0;
         end
      end else if (imiss) begin
         mem_busy = 1'b1;
         mem_cnt  = 3;
         mem_addr = iaddr;
         mem_reqs++;
         if (exp_line_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: got iaddr %h required no request", iaddr);
         end else begin
            chk("req_addr", iaddr, exp_line_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && req && !stall) begin
         if (exp_instr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_instr: got %h required no delivery", instr);
         end else begin
            chk("instr", instr, exp_instr_q.pop_front());
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input logic miss, input logic [31:0] exp_i);
      int n;
      pc  = a;
      req = 1'b1;
      exp_instr_q.push_back(exp_i);
      if (miss) begin
         exp_line_q.push_back({a[31:3], 3'b000});
         exp_misses++;
      end
      exp_hits++;
      @(negedge clk);
      chk("first_stall", stall, miss);
      n = 0;
      while (stall && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (stall) begin
         checks++;
         failures++;
         $display("FAIL fetch_timeout: pc %h stall got 1 required 0", a);
      end
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   n;

      vecs[0] = '{32'h0000_0044, 1'b0, 32'h1111_2222};
      vecs[1] = '{32'h0000_0043, 1'b0, 32'h3333_4444};
      vecs[2] = '{32'h0000_0240, 1'b1, instr_for(32'h240)};
      vecs[3] = '{32'h0000_0244, 1'b0, instr_for(32'h244)};
      vecs[4] = '{32'h0000_0040, 1'b1, 32'h3333_4444};
      vecs[5] = '{32'h0000_01F8, 1'b1, instr_for(32'h1F8)};
      vecs[6] = '{32'hFFFF_FFFC, 1'b1, instr_for(32'hFFFF_FFFC)};
      vecs[7] = '{32'h0000_01FC, 1'b1, instr_for(32'h1FC)};
      vecs[8] = '{32'h0000_0000, 1'b1, instr_for(32'h0)};
      vecs[9] = '{32'h0000_0004, 1'b0, instr_for(32'h4)};

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_imiss", imiss, 1'b0);
      chk("reset_iaddr", iaddr, 32'h0);
      chk("reset_stall", stall, 1'b0);
`ifdef ICACHE_PERF_EN
      chk("reset_hit_count", hit_count, 32'h0);
      chk("reset_miss_count", miss_count, 32'h0);
`endif

      // Cold miss at 0x40 with cycle-level checks around the fill.
      @(posedge clk);
      #1;
      pc  = 32'h40;
      req = 1'b1;
      exp_instr_q.push_back(32'h3333_4444);
      exp_line_q.push_back(32'h40);
      exp_misses++;
      exp_hits++;
      @(negedge clk);
      chk("cold_stall", stall, 1'b1);
      chk("cold_imiss_early", imiss, 1'b0);
      @(negedge clk);
      chk("cold_imiss", imiss, 1'b1);
      chk("cold_iaddr", iaddr, 32'h40);
      n = 0;
      while (!ifill && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cold_ifill_seen", ifill, 1'b1);
      chk("imiss_during_fill", imiss, 1'b1);
      chk("stall_during_fill", stall, 1'b1);
      @(negedge clk);
      chk("imiss_after_fill", imiss, 1'b0);
      chk("refetch_stall", stall, 1'b0);
      @(posedge clk);
      #1;
      req = 1'b0;

      foreach (vecs[i]) fetch(vecs[i].pc, vecs[i].miss, vecs[i].instr);

`ifdef ICACHE_PERF_EN
      chk("hit_count", hit_count, exp_hits);
      chk("miss_count", miss_count, exp_misses);
`endif

      // Reset while waiting on memory, then let the stale fill arrive in IDLE.
      @(posedge clk);
      #1;
      pc  = 32'h300;
      req = 1'b1;
      exp_line_q.push_back(32'h300);
      exp_misses++;
      @(negedge clk);
      @(negedge clk);
      chk("wait_imiss", imiss, 1'b1);
      @(posedge clk);
      #1;
      req   = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_reset_imiss", imiss, 1'b0);
      chk("async_reset_iaddr", iaddr, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0;
      while (!ifill && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stale_ifill_seen", ifill, 1'b1);
      @(posedge clk);
      #1;
      fetch(32'h0, 1'b1, instr_for(32'h0));
      fetch(32'h40, 1'b1, 32'h3333_4444);

`ifdef ICACHE_PERF_EN
      force dut.hit_cnt_q  = 32'hFFFF_FFFF;
      force dut.miss_cnt_q = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      release dut.hit_cnt_q;
      release dut.miss_cnt_q;
      fetch(32'h44, 1'b0, 32'h1111_2222);
      fetch(32'h500, 1'b1, instr_for(32'h500));
      chk("hit_count_sat", hit_count, 32'hFFFF_FFFF);
      chk("miss_count_sat", miss_count, 32'hFFFF_FFFF);
`endif

      repeat (6) @(posedge clk);
      #1;
      chk("mem_request_count", mem_reqs, exp_misses);
      chk("scoreboard_drained", exp_line_q.size() + exp_instr_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
